seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 212 +++++++++++++++++++++
 tb/tb_seg_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// ---------------------------------------------------------------------------
// seg_capture
//
// Purpose:
//   Reads a multiplexed 8-digit, active-low 7-segment display by watching the
//   digit-select (Com) and segment lines. When a Com value has been stable
//   long enough, the segment pattern is decoded into a decimal digit and
//   stored at the selected position. Once all eight positions are filled,
//   the frame is snapshotted and converted to binary (one digit per cycle,
//   most-significant first). The result appears on VALUE with a VALID pulse,
//   or an ERR pulse if any digit in the frame could not be decoded.
//
// Ports:
//   CLK                  clock, all state on rising edge
//   RST                  asynchronous, active-high reset
//   Com[7:0]             digit select, active-low one-hot, Com[0] = LSD
//   AR_SEG_A..AR_SEG_G   segment lines, active-low, pattern {A..G}
//   VALUE[31:0]          last successfully decoded number, binary
//   VALID                one-cycle pulse when VALUE updates
//   ERR                  one-cycle pulse when a frame had an undecodable digit
//   BUSY                 high while the conversion FSM is in CONV
//
// Parameter:
//   SETTLE (2..255)      cycles Com must be held before its digit is sampled
// ---------------------------------------------------------------------------
module seg_capture #(
    parameter int SETTLE = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  Com,
    input  logic        AR_SEG_A,
    input  logic        AR_SEG_B,
    input  logic        AR_SEG_C,
    input  logic        AR_SEG_D,
    input  logic        AR_SEG_E,
    input  logic        AR_SEG_F,
    input  logic        AR_SEG_G,
    output logic [31:0] VALUE,
    output logic        VALID,
    output logic        ERR,
    output logic        BUSY
);

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE);
    localparam logic [7:0] SETTLE_CAP = 8'(SETTLE - 2);

    typedef enum logic {
        COLLECT = 1'b0,
        CONV    = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Input qualification and dwell tracking
    logic [7:0]  com_sel;
    logic        com_valid;
    logic        com_same;
    logic [7:0]  prev_com;
    logic [7:0]  stable_cnt;
    logic        capture;
    logic [7:0]  cap_mask;

    // Segment decode
    logic [6:0]  seg_pat;
    logic [3:0]  dec_digit;
    logic        dec_bad;

    // Frame storage and conversion datapath
    logic [31:0] digits;
    logic [7:0]  bad;
    logic [7:0]  mask;
    logic [31:0] snap;
    logic [7:0]  snap_bad;
    logic [26:0] acc;
    logic [26:0] acc_step;
    logic [2:0]  conv_idx;
    logic        frame_start;
    logic        conv_last;

    // Com selects a digit only when exactly one line is pulled low.
    assign com_sel   = ~Com;
    assign com_valid = (com_sel != 8'h00) && ((com_sel & (com_sel - 8'd1)) == 8'h00);
    assign com_same  = (Com == prev_com);

    // The counter passes SETTLE-2 exactly once per dwell, so this fires once
    // and stays quiet until Com changes.
    assign capture  = com_valid && com_same && (stable_cnt == SETTLE_CAP);
    assign cap_mask = capture ? com_sel : 8'h00;

    assign seg_pat = {AR_SEG_A, AR_SEG_B, AR_SEG_C, AR_SEG_D,
                      AR_SEG_E, AR_SEG_F, AR_SEG_G};

    always_comb begin
        dec_digit = 4'd0;
        dec_bad   = 1'b0;
        case (seg_pat)
            7'b1000000: dec_digit = 4'd0;
            7'b1111001: dec_digit = 4'd1;
            7'b0100100: dec_digit = 4'd2;
            7'b0110000: dec_digit = 4'd3;
            7'b0011001: dec_digit = 4'd4;
            7'b0010010: dec_digit = 4'd5;
            7'b0000010: dec_digit = 4'd6;
            7'b1111000: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0010000: dec_digit = 4'd9;
            default:    dec_bad   = 1'b1;
        endcase
    end

    // One Horner step: digits are consumed most-significant first.
    assign acc_step = (acc * 27'd10) + {23'd0, snap[{conv_idx, 2'b00} +: 4]};

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        conv_last   = 1'b0;
        case (state)
            COLLECT: begin
                // A frame that filled up during CONV is picked up here.
                if (mask == 8'hFF) begin
                    frame_start = 1'b1;
                    state_next  = CONV;
                end
            end
            CONV: begin
                if (conv_idx == 3'd0) begin
                    conv_last  = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign BUSY = (state == CONV);

    // ---------------- Capture path ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_com   <= 8'hFF;
            stable_cnt <= 8'd0;
            digits     <= 32'd0;
            bad        <= 8'h00;
            mask       <= 8'h00;
        end else begin
            prev_com <= Com;
            if (!com_valid || !com_same) begin
                stable_cnt <= 8'd0;
            end else if (stable_cnt != SETTLE_MAX) begin
                stable_cnt <= stable_cnt + 8'd1;
            end

            for (int i = 0; i < 8; i++) begin
                if (cap_mask[i]) begin
                    digits[i*4 +: 4] <= dec_digit;
                    bad[i]           <= dec_bad;
                end
            end

            // A capture landing on the clearing edge belongs to the next
            // frame, so its bit survives the clear.
            mask <= (frame_start ? 8'h00 : mask) | cap_mask;
        end
    end

    // ---------------- Conversion path ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snap     <= 32'd0;
            snap_bad <= 8'h00;
            acc      <= 27'd0;
            conv_idx <= 3'd0;
            VALUE    <= 32'd0;
            VALID    <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            VALID <= 1'b0;
            ERR   <= 1'b0;
            if (frame_start) begin
                // Snapshot takes the stored digits, not a capture on this edge.
                snap     <= digits;
                snap_bad <= bad;
                acc      <= 27'd0;
                conv_idx <= 3'd7;
            end else if (state == CONV) begin
                acc      <= acc_step;
                conv_idx <= conv_idx - 3'd1;
                if (conv_last) begin
                    if (snap_bad == 8'h00) begin
                        VALUE <= {5'd0, acc_step};
                        VALID <= 1'b1;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_seg_capture
//
// Drives a scanning-display model into seg_capture and compares every cycle
// against a frame-level reference: dwell lengths decide captures, a full set
// of eight positions closes a frame, and the frame's decimal value (sum of
// digit * 10^position) is expected nine cycles after the frame filled.
// ---------------------------------------------------------------------------
module tb_seg_capture;

    localparam int SETTLE = 4;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] val;
    } ev_t;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  com_r = 8'hFF;
    logic [6:0]  seg_r = 7'h7F;
    logic [31:0] VALUE;
    logic        VALID;
    logic        ERR;
    logic        BUSY;

    always #5 CLK = ~CLK;

    seg_capture #(.SETTLE(SETTLE)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Com      (com_r),
        .AR_SEG_A (seg_r[6]),
        .AR_SEG_B (seg_r[5]),
        .AR_SEG_C (seg_r[4]),
        .AR_SEG_D (seg_r[3]),
        .AR_SEG_E (seg_r[2]),
        .AR_SEG_F (seg_r[1]),
        .AR_SEG_G (seg_r[0]),
        .VALUE    (VALUE),
        .VALID    (VALID),
        .ERR      (ERR),
        .BUSY     (BUSY)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_valid_seen = 0;
    int n_err_seen   = 0;

    ev_t exp_q[$];
    logic [31:0] exp_value = 32'd0;

    int          edge_n     = 0;
    int          conv_start = -100;
    int          conv_end   = -100;
    int          run_len    = 0;
    logic [7:0]  m_prev     = 8'hFF;
    logic [7:0]  m_mask     = 8'h00;
    int          m_dig [8];
    logic [7:0]  m_bad      = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [55:0] pats_of(input int n);
        logic [55:0] p;
        int v;
        p = '0;
        v = n;
        for (int i = 0; i < 8; i++) begin
            p[i*7 +: 7] = seg_of(v % 10);
            v = v / 10;
        end
        return p;
    endfunction

    // ---------------- reference model (per rising edge) ----------------
    always @(posedge CLK) begin
        int pos;
        int d;
        bit b;
        int v;
        int p10;
        bit fb;
        edge_n++;
        if (RST) begin
            run_len    = 0;
            m_prev     = 8'hFF;
            m_mask     = 8'h00;
            m_bad      = 8'h00;
            conv_start = -100;
            conv_end   = -100;
            for (int i = 0; i < 8; i++) m_dig[i] = 0;
            exp_q.delete();
        end else begin
            if ($countones(com_r) == 7) begin
                run_len = (com_r == m_prev) ? run_len + 1 : 1;
            end else begin
                run_len = 0;
            end
            m_prev = com_r;

            // A full frame is taken once the converter is idle again.
            if (m_mask == 8'hFF && edge_n > conv_end) begin
                v = 0;
                p10 = 1;
                fb = 0;
                for (int i = 0; i < 8; i++) begin
                    v = v + m_dig[i] * p10;
                    p10 = p10 * 10;
                    fb = fb | m_bad[i];
                end
                exp_q.push_back('{cyc: edge_n + 8, err: fb, val: 32'(v)});
                conv_start = edge_n;
                conv_end   = edge_n + 8;
                m_mask     = 8'h00;
            end

            if (run_len == SETTLE) begin
                pos = 0;
                for (int i = 0; i < 8; i++) if (com_r[i] == 1'b0) pos = i;
                d = 0;
                b = 1;
                for (int k = 0; k < 10; k++) begin
                    if (seg_r == seg_of(k)) begin
                        d = k;
                        b = 0;
                    end
                end
                m_dig[pos]  = d;
                m_bad[pos]  = b;
                m_mask[pos] = 1'b1;
            end
        end
    end

    // ---------------- output monitor (falling edge) ----------------
    always @(negedge CLK) begin
        bit due;
        bit derr;
        ev_t ev;
        if (RST) begin
            exp_value = 32'd0;
        end else begin
            due  = 0;
            derr = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                ev = exp_q.pop_front();
                due  = 1;
                derr = ev.err;
                if (!ev.err) exp_value = ev.val;
            end
            if (VALID === 1'b1) n_valid_seen++;
            if (ERR === 1'b1)   n_err_seen++;
            check("valid", VALID, due && !derr);
            check("err",   ERR,   due && derr);
            check("busy",  BUSY,  edge_n >= conv_start && edge_n < conv_end);
            check("value", VALUE, exp_value);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] c, input logic [6:0] s);
        com_r = c;
        seg_r = s;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'hFF, seg_r);
    endtask

    // Segments may lag the digit select by `lag` cycles.
    task automatic show_digit(input int pos, input logic [6:0] pat, input int dwell, input int lag);
        for (int k = 0; k < dwell; k++) begin
            drive(~(8'b1 << pos), (k < lag) ? seg_r : pat);
        end
    endtask

    task automatic scan(input logic [55:0] p, input int dwell, input int lag);
        for (int i = 0; i < 8; i++) show_digit(i, p[i*7 +: 7], dwell, lag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int v0;
        int e0;
        int old_cs;
        bit found;
        logic [55:0] p;
        int order [8];
        int j;
        int t;

        // Asynchronous reset before any clock edge.
        #2 RST = 1'b1;
        #1;
        check("rst_value", VALUE, 32'd0);
        check("rst_valid", VALID, 1'b0);
        check("rst_err",   ERR,   1'b0);
        check("rst_busy",  BUSY,  1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        idle(3);

        // Long-dwell scanning display with one-cycle segment lag.
        v0 = n_valid_seen;
        e0 = n_err_seen;
        scan(pats_of(12345678), 1024, 1);
        scan(pats_of(12345678), 1024, 1);
        idle(12);
        check("scan_valid_cnt", n_valid_seen - v0, 2);
        check("scan_err_cnt",   n_err_seen - e0, 0);
        check("scan_value",     VALUE, 32'd12345678);

        // All-zero and all-nine displays.
        scan(pats_of(0), 6, 1);
        idle(12);
        check("zeros_value", VALUE, 32'd0);
        scan(pats_of(99999999), 6, 1);
        idle(12);
        check("nines_value", VALUE, 32'h05F5E0FF);

        // Invalid selects and short dwells must not capture.
        p = pats_of(87654321);
        for (int i = 1; i < 8; i++) show_digit(i, p[i*7 +: 7], 5, 0);
        v0 = n_valid_seen;
        repeat (20) drive(8'hFF, seg_r);
        repeat (20) drive(8'hFC, p[6:0]);
        show_digit(0, p[6:0], SETTLE - 1, 0);
        idle(1);
        show_digit(0, p[6:0], SETTLE - 1, 0);
        idle(15);
        check("no_capture_valid", n_valid_seen - v0, 0);
        show_digit(0, p[6:0], SETTLE, 0);
        idle(12);
        check("short_dwell_value", VALUE, 32'd87654321);

        // Undecodable digit 3, then a clean frame.
        v0 = n_valid_seen;
        e0 = n_err_seen;
        p = pats_of(24681357);
        p[3*7 +: 7] = 7'b1111111;
        scan(p, 5, 1);
        idle(12);
        check("bad_err_cnt",   n_err_seen - e0, 1);
        check("bad_valid_cnt", n_valid_seen - v0, 0);
        check("bad_value_kept", VALUE, 32'd87654321);
        scan(pats_of(24681357), 5, 1);
        idle(12);
        check("clean_value", VALUE, 32'd24681357);

        // Reset during the fourth conversion cycle.
        old_cs = conv_start;
        scan(pats_of(31415926), 6, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (conv_start != old_cs && edge_n == conv_start + 3) found = 1;
            else @(negedge CLK);
        end
        check("rst_conv_reach", found, 1'b1);
        check("rst_conv_busy", BUSY, 1'b1);
        RST = 1'b1;
        #1;
        check("rst_mid_value", VALUE, 32'd0);
        check("rst_mid_valid", VALID, 1'b0);
        check("rst_mid_err",   ERR,   1'b0);
        check("rst_mid_busy",  BUSY,  1'b0);
        com_r = 8'hFF;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        v0 = n_valid_seen;
        e0 = n_err_seen;
        idle(15);
        check("rst_no_valid", n_valid_seen - v0, 0);
        check("rst_no_err",   n_err_seen - e0, 0);
        scan(pats_of(31415926), 6, 1);
        idle(12);
        check("post_rst_value", VALUE, 32'd31415926);

        // Randomized frames with glitches, short dwells and bad patterns.
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 8; i++) begin
                p[i*7 +: 7] = seg_of($urandom_range(9, 0));
                if ($urandom_range(11, 0) == 0) p[i*7 +: 7] = 7'($urandom);
                order[i] = i;
            end
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
            idle(1);
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(4, 0))
                    0: idle($urandom_range(3, 1));
                    1: begin
                        show_digit(order[k], p[order[k]*7 +: 7], SETTLE - 1, 0);
                        idle(1);
                    end
                    default: ;
                endcase
                show_digit(order[k], p[order[k]*7 +: 7],
                           $urandom_range(SETTLE + 4, SETTLE), $urandom_range(1, 0));
            end
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
